tv80_bus_arbiter: RTL



---
 rtl/tv80_bus_arbiter_if.sv | 23 ++
 rtl/tv80_bus_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tv80_bus_arbiter_if.sv
// Bus-request/grant bundle shared by tv80_bus_arbiter, its requesters and the CPU handshake.
// master = arbiter side, slave = requesters/CPU side.
interface tv80_bus_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      bus_sel;
    logic            cpu_owns;
    logic            preempt;
    logic            cpu_busrq_n;
    logic            cpu_busak_n;

    modport master (
        input  req, cpu_busak_n,
        output gnt, bus_sel, cpu_owns, preempt, cpu_busrq_n
    );

    modport slave (
        output req, cpu_busak_n,
        input  gnt, bus_sel, cpu_owns, preempt, cpu_busrq_n
    );
endinterface

// File: rtl/tv80_bus_arbiter.sv
// Hands the tv80 system bus to one of NREQ requesters via busrq_n/busak_n, with a hold timer.
// Optional macro TV80_ARB_RR_EN selects round-robin winner selection instead of fixed priority.
module tv80_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cen,
    tv80_bus_arbiter_if.master bus
);
    localparam int              CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_GRANT, S_RELEASE} state_t;

    state_t          r_state, w_state_next;
    logic [NREQ-1:0] r_gnt, w_gnt_next;
    logic [1:0]      r_bus_sel, w_bus_sel_next;
    logic            r_cpu_owns, w_cpu_owns_next;
    logic            r_preempt, w_preempt_next;
    logic            r_busrq_n, w_busrq_n_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;

    logic            w_any;
    logic            w_held;
    logic [NREQ-1:0] w_req_rot;
    logic [1:0]      w_base;
    logic [1:0]      w_win;
    logic [NREQ-1:0] w_win_onehot;

    assign w_any  = |bus.req;
    assign w_held = |(bus.req & r_gnt);

`ifdef TV80_ARB_RR_EN
    logic [1:0]        r_ptr;
    logic [2*NREQ-1:0] w_req_dbl;

    // Rotate so that bit 0 of w_req_rot is the requester the pointer names.
    assign w_req_dbl = {bus.req, bus.req};
    assign w_req_rot = NREQ'(w_req_dbl >> r_ptr);
    assign w_base    = r_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= 2'd0;
        end else if (cen && r_state == S_REQ && w_any && !bus.cpu_busak_n) begin
            r_ptr <= 2'((int'(w_win) + 1) % NREQ);
        end
    end
`else
    assign w_req_rot = bus.req;
    assign w_base    = 2'd0;
`endif

    // Lowest set bit of the (possibly rotated) request vector wins.
    always_comb begin
        w_win = 2'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_win = 2'((int'(w_base) + k) % NREQ);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
            assign w_win_onehot[gi] = (w_win == 2'(gi));
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_gnt_next      = r_gnt;
        w_bus_sel_next  = r_bus_sel;
        w_cpu_owns_next = r_cpu_owns;
        w_preempt_next  = 1'b0;
        w_busrq_n_next  = r_busrq_n;
        w_cnt_next      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_next   = S_REQ;
                    w_busrq_n_next = 1'b0;
                end
            end
            S_REQ: begin
                if (!w_any) begin
                    w_state_next    = S_RELEASE;
                    w_busrq_n_next  = 1'b1;
                    w_cpu_owns_next = 1'b1;
                end else if (!bus.cpu_busak_n) begin
                    w_state_next    = S_GRANT;
                    w_gnt_next      = w_win_onehot;
                    w_bus_sel_next  = w_win;
                    w_cpu_owns_next = 1'b0;
                    w_cnt_next      = '0;
                end
            end
            S_GRANT: begin
                w_cnt_next = r_cnt + 1'b1;
                // Request drop and CPU protocol error both win over timer expiry: no preempt.
                if (!w_held || bus.cpu_busak_n) begin
                    w_state_next    = S_RELEASE;
                    w_gnt_next      = '0;
                    w_busrq_n_next  = 1'b1;
                    w_cpu_owns_next = 1'b1;
                end else if (MAX_HOLD != 0 && r_cnt == HOLD_LAST) begin
                    w_state_next    = S_RELEASE;
                    w_gnt_next      = '0;
                    w_busrq_n_next  = 1'b1;
                    w_cpu_owns_next = 1'b1;
                    w_preempt_next  = 1'b1;
                end
            end
            S_RELEASE: begin
                if (bus.cpu_busak_n) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_gnt      <= '0;
            r_bus_sel  <= 2'd0;
            r_cpu_owns <= 1'b1;
            r_preempt  <= 1'b0;
            r_busrq_n  <= 1'b1;
            r_cnt      <= '0;
        end else if (cen) begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_bus_sel  <= w_bus_sel_next;
            r_cpu_owns <= w_cpu_owns_next;
            r_preempt  <= w_preempt_next;
            r_busrq_n  <= w_busrq_n_next;
            r_cnt      <= w_cnt_next;
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.bus_sel     = r_bus_sel;
    assign bus.cpu_owns    = r_cpu_owns;
    assign bus.preempt     = r_preempt;
    assign bus.cpu_busrq_n = r_busrq_n;
endmodule
